// File: rtl/user_pulse_seq_pkg.sv
// Shared types and helpers for the multi-phase pulse sequencer.
package user_pulse_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Upper bound on phases the search helper can scan; the index field is sized for it.
  localparam int MAX_PHASES = 64;
  localparam int IDX_W      = 6;

  function automatic int ph_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Phase index width for the default four-phase build.
  localparam int PH_W = ph_width(4);

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } next_t;

  // Lowest active phase at or above 'from'.
  function automatic next_t next_active(input logic [MAX_PHASES-1:0] mask, input int from);
    next_t r;
    r = '0;
    for (int i = MAX_PHASES - 1; i >= 0; i--) begin
      if (mask[i] && i >= from) begin
        r.found = 1'b1;
        r.idx   = IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/user_pulse_phase_timer.sv
// Cycle and pulse counters for the currently selected phase.
module user_pulse_phase_timer #(
  parameter int CNT_W  = 16,
  parameter int PCNT_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear,
  input  logic              enable,
  input  logic [CNT_W-1:0]  period,
  input  logic [CNT_W-1:0]  high,
  input  logic [PCNT_W-1:0] count,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic              level,
  output logic              wrap,
  output logic              phase_last
);

  logic [PCNT_W-1:0] pulse_cnt;

  assign wrap       = enable && (cyc_cnt == period - CNT_W'(1));
  assign phase_last = (pulse_cnt == count - PCNT_W'(1));
  assign level      = (cyc_cnt < high);

  // Both counters return to zero by themselves at the end of a phase, so
  // back-to-back phases and loop restarts need no extra clear cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      cyc_cnt   <= '0;
      pulse_cnt <= '0;
    end else if (enable) begin
      if (wrap) begin
        cyc_cnt   <= '0;
        pulse_cnt <= phase_last ? '0 : pulse_cnt + PCNT_W'(1);
      end else begin
        cyc_cnt <= cyc_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/user_pulse_seq.sv
// Multi-phase pulse sequencer: FSM, shadowed config, phase selection and loop count.
module user_pulse_seq
  import user_pulse_seq_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int CNT_W      = 16,
  parameter int PCNT_W     = 8,
  parameter int LOOP_W     = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic                             stop_i,
  input  logic [NUM_PHASES*CNT_W-1:0]      period_i,
  input  logic [NUM_PHASES*CNT_W-1:0]      high_i,
  input  logic [NUM_PHASES*PCNT_W-1:0]     count_i,
  input  logic [NUM_PHASES-1:0]            invert_i,
  input  logic [LOOP_W-1:0]                loops_i,
  input  logic                             loop_forever_i,
  output logic                             pulse_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [ph_width(NUM_PHASES)-1:0]  phase_o,
  output logic [1:0]                       state_o
);

  localparam int PHW = ph_width(NUM_PHASES);

  state_t                               state;
  logic [NUM_PHASES-1:0][CNT_W-1:0]     sh_period, sh_high;
  logic [NUM_PHASES-1:0][PCNT_W-1:0]    sh_count;
  logic [NUM_PHASES-1:0]                sh_invert;
  logic                                 sh_forever;
  logic [LOOP_W-1:0]                    loop_rem;
  logic [PHW-1:0]                       phase;

  logic [NUM_PHASES-1:0] in_act, sh_act;
  next_t                 in_first, sh_first, sh_next;

  logic             run, tmr_clear, level, wrap, phase_last;
  logic [CNT_W-1:0] cyc_cnt, cur_period;

  for (genvar k = 0; k < NUM_PHASES; k++) begin : g_act
    assign in_act[k] = (count_i[k*PCNT_W +: PCNT_W] != '0) && (period_i[k*CNT_W +: CNT_W] != '0);
    assign sh_act[k] = (sh_count[k] != '0) && (sh_period[k] != '0);
  end

  assign in_first = next_active(MAX_PHASES'(in_act), 0);
  assign sh_first = next_active(MAX_PHASES'(sh_act), 0);
  assign sh_next  = next_active(MAX_PHASES'(sh_act), int'(phase) + 1);

  assign run        = (state == RUN);
  assign tmr_clear  = !run || stop_i;
  assign cur_period = sh_period[phase];

  user_pulse_phase_timer #(
    .CNT_W  (CNT_W),
    .PCNT_W (PCNT_W)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear      (tmr_clear),
    .enable     (run),
    .period     (cur_period),
    .high       (sh_high[phase]),
    .count      (sh_count[phase]),
    .cyc_cnt    (cyc_cnt),
    .level      (level),
    .wrap       (wrap),
    .phase_last (phase_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      phase      <= '0;
      loop_rem   <= '0;
      sh_period  <= '0;
      sh_high    <= '0;
      sh_count   <= '0;
      sh_invert  <= '0;
      sh_forever <= 1'b0;
    end else if (stop_i) begin
      state <= IDLE;
      phase <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          sh_period  <= period_i;
          sh_high    <= high_i;
          sh_count   <= count_i;
          sh_invert  <= invert_i;
          sh_forever <= loop_forever_i;
          loop_rem   <= loops_i;
          if (in_first.found) begin
            state <= RUN;
            phase <= PHW'(in_first.idx);
          end else begin
            state <= DONE;
          end
        end
        RUN: if (wrap && phase_last) begin
          if (sh_next.found) begin
            phase <= PHW'(sh_next.idx);
          end else if (sh_forever) begin
            phase <= PHW'(sh_first.idx);
          end else if (loop_rem != '0) begin
            loop_rem <= loop_rem - LOOP_W'(1);
            phase    <= PHW'(sh_first.idx);
          end else begin
            state <= DONE;
            phase <= '0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o  = run;
  assign done_o  = (state == DONE);
  assign pulse_o = run && (level ^ sh_invert[phase]);
  assign phase_o = run ? phase : '0;
  assign state_o = state;

  a_cyc_in_range: assert property (@(posedge clk_i) disable iff (rst_i) run |-> cyc_cnt < cur_period);

endmodule

// File: tb/tb_user_pulse_seq.sv
// Scoreboard bench: a trace-building reference model predicts every output cycle.
module tb_user_pulse_seq;
  import user_pulse_seq_pkg::*;

  localparam int NP = 4, CW = 16, PW = 8, LW = 8;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, forever_v = 1'b0;
  logic [NP*CW-1:0] period_v = '0, high_v = '0;
  logic [NP*PW-1:0] count_v = '0;
  logic [NP-1:0]    invert_v = '0;
  logic [LW-1:0]    loops_v = '0;

  logic            pulse, busy, done;
  logic [PH_W-1:0] phase;
  logic [1:0]      state;

  user_pulse_seq #(.NUM_PHASES(NP), .CNT_W(CW), .PCNT_W(PW), .LOOP_W(LW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
    .period_i(period_v), .high_i(high_v), .count_i(count_v), .invert_i(invert_v),
    .loops_i(loops_v), .loop_forever_i(forever_v),
    .pulse_o(pulse), .busy_o(busy), .done_o(done), .phase_o(phase), .state_o(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            pulse;
    logic            busy;
    logic            done;
    logic [PH_W-1:0] phase;
    logic [1:0]      state;
  } obs_t;

  obs_t trace[$];  // predicted outputs of the run in progress
  obs_t sb[$];     // one expected observation per clock edge
  int   n_checks = 0, n_fail = 0;

  function automatic obs_t mk(bit p, bit b, bit d, int ph, int st);
    obs_t o;
    o.pulse = p; o.busy = b; o.done = d;
    o.phase = PH_W'(ph); o.state = 2'(st);
    return o;
  endfunction

  // Expand the whole run from the rules: each active phase contributes
  // count*period cycles, the pass repeats loops+1 times, then one DONE cycle.
  function automatic void build();
    int act[$];
    int per, hi, cnt;
    for (int k = 0; k < NP; k++)
      if (count_v[k*PW +: PW] != 0 && period_v[k*CW +: CW] != 0) act.push_back(k);
    if (act.size() == 0) begin
      trace.push_back(mk(0, 0, 1, 0, 2));
      return;
    end
    for (int pass = 0; forever_v ? (trace.size() < 3000) : (pass <= int'(loops_v)); pass++)
      foreach (act[j]) begin
        per = int'(period_v[act[j]*CW +: CW]);
        hi  = int'(high_v[act[j]*CW +: CW]);
        cnt = int'(count_v[act[j]*PW +: PW]);
        for (int p = 0; p < cnt; p++)
          for (int c = 0; c < per; c++)
            trace.push_back(mk((c < hi) ^ invert_v[act[j]], 1, 0, act[j], 1));
      end
    if (!forever_v) trace.push_back(mk(0, 0, 1, 0, 2));
  endfunction

  task automatic step();
    if (rst || stop)           trace.delete();
    else if (trace.size() == 0) begin if (start) build(); end
    else                        void'(trace.pop_front());
    sb.push_back(trace.size() != 0 ? trace[0] : mk(0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
  endtask

  task automatic steps(int n);
    repeat (n) step();
  endtask

  task automatic set_ph(int k, int cnt, int per, int hi, bit inv);
    count_v[k*PW +: PW]  = PW'(cnt);
    period_v[k*CW +: CW] = CW'(per);
    high_v[k*CW +: CW]   = CW'(hi);
    invert_v[k]          = inv;
  endtask

  task automatic cfg_clear();
    period_v = '0; high_v = '0; count_v = '0; invert_v = '0; loops_v = '0; forever_v = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1; step(); start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      obs_t e, a;
      e = sb.pop_front();
      a = {pulse, busy, done, phase, state};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_outputs @%0t: got pulse=%0b busy=%0b done=%0b phase=%0d state=%0d, want pulse=%0b busy=%0b done=%0b phase=%0d state=%0d",
                 $time, a.pulse, a.busy, a.done, a.phase, a.state, e.pulse, e.busy, e.done, e.phase, e.state);
      end
    end
  end

  initial begin
    steps(3);
    rst = 1'b0;
    steps(2);

    // single phase, two pulses
    cfg_clear(); set_ph(0, 2, 4, 1, 0);
    kick(); steps(12);

    // skipped phase 0, inverted phase 1, seamless into phase 2
    cfg_clear(); set_ph(1, 1, 3, 1, 1); set_ph(2, 1, 2, 1, 0);
    kick(); steps(8);

    // two extra loops
    cfg_clear(); set_ph(0, 1, 2, 1, 0); loops_v = 2;
    kick(); steps(10);

    // run forever, then stop
    forever_v = 1'b1;
    kick(); steps(100);
    stop = 1'b1; step(); stop = 1'b0; steps(4);

    // reprogramming mid-run leaves timing alone
    cfg_clear(); set_ph(0, 2, 5, 2, 0);
    kick(); steps(3);
    set_ph(0, 3, 2, 1, 1); set_ph(1, 2, 3, 1, 0); loops_v = 3;
    steps(15);

    // start together with stop does nothing
    start = 1'b1; stop = 1'b1; step();
    start = 1'b0; stop = 1'b0; steps(3);

    // reset in the middle of a run
    cfg_clear(); set_ph(0, 3, 4, 2, 0);
    kick(); steps(5);
    rst = 1'b1; step(); rst = 1'b0; steps(3);

    // nothing active: straight to DONE
    cfg_clear();
    kick(); steps(3);

    // high >= period: constant levels
    cfg_clear(); set_ph(0, 3, 3, 5, 0); set_ph(2, 1, 2, 2, 1); set_ph(3, 2, 2, 0, 0);
    kick(); steps(16);

    // randomized config, start, stop and reset, changing freely during runs
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < NP; k++)
          set_ph(k, $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 6), 1'($urandom_range(0, 1)));
        loops_v   = LW'($urandom_range(0, 2));
        forever_v = ($urandom_range(0, 7) == 0);
      end
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      step();
    end
    start = 1'b0; rst = 1'b0; stop = 1'b1; steps(2);
    stop = 1'b0; steps(3);

    // longest legal period
    cfg_clear(); set_ph(0, 1, 16'hFFFF, 16'h8000, 0);
    kick(); steps(65540);

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
